// File: rtl/data_ram_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_unit_if
//  Description : LSU <-> data RAM request/response bundle. The LSU side is
//                the master (drives requests), the RAM side is the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_ram_unit_if;
   logic        data_req_in;
   logic [31:0] data_add_in;
   logic        data_we_in;
   logic [3:0]  data_be_in;
   logic [31:0] data_wdata_in;
   logic [4:0]  rd_in_data;
   logic        data_gnt_o;
   logic        data_rvalid;
   logic [31:0] data_rdata_o;
   logic [4:0]  rd_out_data;

   modport master (
      output data_req_in, data_add_in, data_we_in, data_be_in,
             data_wdata_in, rd_in_data,
      input  data_gnt_o, data_rvalid, data_rdata_o, rd_out_data
   );

   modport slave (
      input  data_req_in, data_add_in, data_we_in, data_be_in,
             data_wdata_in, rd_in_data,
      output data_gnt_o, data_rvalid, data_rdata_o, rd_out_data
   );
endinterface
`default_nettype wire

// File: rtl/data_ram_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram_unit
//  Description : Single-port word-organised data RAM for the load/store unit.
//                Byte-enable writes, one-cycle registered read response that
//                carries the load's destination-register tag.
//  Revision    : 1.0  initial release
// ============================================================================
module data_ram_unit #(
   parameter int DEPTH_WORDS = 1024
) (
   input  wire logic      req,     // clock
   input  wire logic      reset,   // asynchronous, active-low
   data_ram_unit_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH_WORDS);

   logic [31:0]       mem [DEPTH_WORDS];
   logic [ADDR_W-1:0] word_idx;
   logic              accept;
   logic              rvalid_q;
   logic [31:0]       rdata_q;
   logic [4:0]        tag_q;
   logic              unused_addr_bits;

   // Byte offset and bits above the array size are dropped, so addresses
   // alias modulo DEPTH_WORDS*4 and misalignment is left to the LSU.
   assign word_idx         = bus.data_add_in[ADDR_W+1:2];
   assign unused_addr_bits = ^{bus.data_add_in[31:ADDR_W+2], bus.data_add_in[1:0]};

   // The RAM never stalls, so every request is granted unless held in reset.
   // An unknown request makes the if() conditions below false: no update.
   assign accept         = reset & bus.data_req_in;
   assign bus.data_gnt_o = accept;

   assign bus.data_rvalid  = rvalid_q;
   assign bus.data_rdata_o = rdata_q;
   assign bus.rd_out_data  = tag_q;

   // Byte-lane writes; the array has no reset so contents survive reset.
   always_ff @(posedge req) begin
      if (accept && bus.data_we_in) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.data_be_in[i]) begin
               mem[word_idx][8*i +: 8] <= bus.data_wdata_in[8*i +: 8];
            end
         end
      end
   end

   // Response register: one-cycle valid pulse, data and tag hold while idle.
   always_ff @(posedge req or negedge reset) begin
      if (!reset) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         tag_q    <= '0;
      end else if (accept) begin
         rvalid_q <= 1'b1;
         tag_q    <= bus.rd_in_data;
         rdata_q  <= bus.data_we_in ? 32'h0 : mem[word_idx];
      end else begin
         rvalid_q <= 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_ram_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_ram_unit
//  Description : Self-checking bench for data_ram_unit. Expected responses
//                are pushed to a queue as requests are driven and popped when
//                the response appears one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_ram_unit;
   localparam int DEPTH  = 1024;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  tag;
   } resp_t;

   logic        clk;
   logic        reset;
   int          passed;
   int          total;
   resp_t       sb [$];
   logic [31:0] model [DEPTH];

   data_ram_unit_if bus ();

   data_ram_unit #(.DEPTH_WORDS(DEPTH)) dut (
      .req   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one request and, if it will be accepted, record its response.
   task automatic issue(input logic r, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic [4:0] tag);
      logic [ADDR_W-1:0] idx;
      resp_t e;
      bus.data_req_in   = r;
      bus.data_we_in    = we;
      bus.data_add_in   = addr;
      bus.data_be_in    = be;
      bus.data_wdata_in = wd;
      bus.rd_in_data    = tag;
      idx = addr[ADDR_W+1:2];
      if (r && reset) begin
         e.tag = tag;
         if (we) begin
            e.rdata = 32'h0;
            for (int i = 0; i < 4; i++)
               if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
         end else begin
            e.rdata = model[idx];
         end
         sb.push_back(e);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      resp_t e;
      reset = 1'b0;
      issue(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
      #1;
      total++;
      if (bus.data_gnt_o !== 1'b0)
         $display("FAIL reset_gnt: gnt=%b expected 0", bus.data_gnt_o);
      else passed++;
      total++;
      if (bus.data_rvalid !== 1'b0 || bus.data_rdata_o !== 32'h0 || bus.rd_out_data !== 5'd0)
         $display("FAIL reset_outputs: rvalid=%b rdata=%h tag=%0d expected 0/0/0",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;
      step;
      total++;
      if (bus.data_rvalid !== 1'b0)
         $display("FAIL reset_no_resp: rvalid=%b expected 0", bus.data_rvalid);
      else passed++;

      reset = 1'b1;
      issue(1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 5'd1);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== e.rdata || bus.rd_out_data !== e.tag)
         $display("FAIL reset_prewrite: rvalid=%b rdata=%h tag=%0d expected 1 %h %0d",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, e.rdata, e.tag);
      else passed++;
      issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 5'd3);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'hCAFEF00D || bus.rd_out_data !== 5'd3)
         $display("FAIL reset_preread: rvalid=%b rdata=%h tag=%0d expected 1 cafef00d 3",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;

      // Assert reset in the middle of a valid response.
      issue(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
      #2 reset = 1'b0;
      #1;
      total++;
      if (bus.data_rvalid !== 1'b0 || bus.data_rdata_o !== 32'h0 || bus.rd_out_data !== 5'd0)
         $display("FAIL reset_async_clear: rvalid=%b rdata=%h tag=%0d expected 0/0/0",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;

      // A request issued just before reset asserts gets no response.
      step;
      reset = 1'b1;
      issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 5'd4);
      #2 reset = 1'b0;
      step;
      sb.delete();
      total++;
      if (bus.data_rvalid !== 1'b0)
         $display("FAIL reset_inflight_dropped: rvalid=%b expected 0", bus.data_rvalid);
      else passed++;

      reset = 1'b1;
      issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 5'd6);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'hCAFEF00D || bus.rd_out_data !== 5'd6)
         $display("FAIL reset_mem_kept: rvalid=%b rdata=%h tag=%0d expected 1 cafef00d 6",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;
   endtask

   task automatic test_full_rw;
      resp_t e;
      issue(1'b1, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 5'd1);
      #1;
      total++;
      if (bus.data_gnt_o !== 1'b1)
         $display("FAIL full_gnt: gnt=%b expected 1", bus.data_gnt_o);
      else passed++;
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'h0 || bus.rd_out_data !== e.tag)
         $display("FAIL full_write_resp: rvalid=%b rdata=%h tag=%0d expected 1 0 %0d",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, e.tag);
      else passed++;
      issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 5'd5);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'hDEADBEEF || bus.rd_out_data !== 5'd5)
         $display("FAIL full_read: rvalid=%b rdata=%h tag=%0d expected 1 deadbeef 5",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;
   endtask

   task automatic test_byte_enables;
      resp_t e;
      logic [31:0] want [4];
      want[0] = 32'h0;
      want[1] = 32'hDE22BE44;
      want[2] = 32'h0;
      want[3] = 32'hDE22BE44;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: issue(1'b1, 1'b1, 32'h40, 4'b0101, 32'h11223344, 5'd8);
            1: issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 5'd9);
            2: issue(1'b1, 1'b1, 32'h40, 4'b0000, 32'hFFFFFFFF, 5'd10);
            default: issue(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 5'd11);
         endcase
         step;
         e = sb.pop_front();
         total++;
         if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== want[i] || bus.rd_out_data !== e.tag)
            $display("FAIL byte_en_%0d: rvalid=%b rdata=%h tag=%0d expected 1 %h %0d",
                     i, bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, want[i], e.tag);
         else passed++;
      end
   endtask

   task automatic test_align_wrap;
      resp_t e;
      logic [31:0] addrs [2];
      addrs[0] = 32'h43;
      addrs[1] = 32'h40 + DEPTH * 4;
      for (int i = 0; i < 2; i++) begin
         issue(1'b1, 1'b0, addrs[i], 4'h0, 32'h0, 5'(12 + i));
         step;
         e = sb.pop_front();
         total++;
         if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'hDE22BE44 || bus.rd_out_data !== e.tag)
            $display("FAIL align_wrap_%h: rvalid=%b rdata=%h tag=%0d expected 1 de22be44 %0d",
                     addrs[i], bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, e.tag);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      resp_t e;
      issue(1'b1, 1'b1, 32'h80, 4'hF, 32'h0000000A, 5'd2);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'h0 || bus.rd_out_data !== 5'd2)
         $display("FAIL raw_write: rvalid=%b rdata=%h tag=%0d expected 1 0 2",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;
      issue(1'b1, 1'b0, 32'h80, 4'h0, 32'h0, 5'd7);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'h0000000A || bus.rd_out_data !== 5'd7)
         $display("FAIL raw_read: rvalid=%b rdata=%h tag=%0d expected 1 0000000a 7",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;

      // Continuous stream: full writes, partial overwrites, then reads.
      for (int i = 0; i < 24; i++) begin
         if (i < 8)
            issue(1'b1, 1'b1, 32'h200 + 32'(4 * i), 4'hF, $urandom, 5'(i));
         else if (i < 16)
            issue(1'b1, 1'b1, 32'h200 + 32'(4 * (i - 8)), 4'($urandom_range(0, 15)),
                  $urandom, 5'(i));
         else
            issue(1'b1, 1'b0, 32'h200 + 32'(4 * (i - 16)), 4'h0, 32'h0, 5'(i));
         step;
         e = sb.pop_front();
         total++;
         if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== e.rdata || bus.rd_out_data !== e.tag)
            $display("FAIL stream_%0d: rvalid=%b rdata=%h tag=%0d expected 1 %h %0d",
                     i, bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, e.rdata, e.tag);
         else passed++;
      end
   endtask

   task automatic test_idle;
      resp_t e;
      logic [31:0] last_rdata;
      logic [4:0]  last_tag;
      last_rdata = bus.data_rdata_o;
      last_tag   = bus.rd_out_data;
      issue(1'b0, 1'b1, 32'h40, 4'hF, 32'h00000000, 5'd30);
      #1;
      total++;
      if (bus.data_gnt_o !== 1'b0)
         $display("FAIL idle_gnt: gnt=%b expected 0", bus.data_gnt_o);
      else passed++;
      step;
      total++;
      if (bus.data_rvalid !== 1'b0 || bus.data_rdata_o !== last_rdata || bus.rd_out_data !== last_tag)
         $display("FAIL idle_hold: rvalid=%b rdata=%h tag=%0d expected 0 %h %0d",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data, last_rdata, last_tag);
      else passed++;
      issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 5'd31);
      step;
      e = sb.pop_front();
      total++;
      if (bus.data_rvalid !== 1'b1 || bus.data_rdata_o !== 32'hDE22BE44 || bus.rd_out_data !== 5'd31)
         $display("FAIL idle_no_write: rvalid=%b rdata=%h tag=%0d expected 1 de22be44 31",
                  bus.data_rvalid, bus.data_rdata_o, bus.rd_out_data);
      else passed++;
      issue(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
      step;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b0;
      issue(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 5'd0);
      step;
      test_reset;
      test_full_rw;
      test_byte_enables;
      test_align_wrap;
      test_back_to_back;
      test_idle;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/data_ram_unit.md
Name: data_ram_unit

Overview:
- Single-port, word-organised data memory serving the core's load/store unit (LSU).
- Accepts one request per clock with byte-enable writes.
- Returns read data one cycle after the request, with a valid pulse.
- Carries the load's destination-register tag alongside the data so the LSU can retire the load into the register file.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored.
- ADDR_W, clog2(DEPTH_WORDS), derived word-index width (do not override).

Ports:
- req  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset reset, asynchronous, active-low.
- data_req_in  input  1  access request from LSU.
- data_add_in  input  32  byte address.
- data_we_in  input  1  1 = write, 0 = read.
- data_be_in  input  4  byte enables; bit i covers data bits [8i+7:8i].
- data_wdata_in  input  32  write data, already lane-aligned by the LSU.
- rd_in_data  input  5  destination register tag of the request.
- data_gnt_o  output  1  request granted.
- data_rvalid  output  1  response valid, one-cycle pulse.
- data_rdata_o  output  32  read data (full word).
- rd_out_data  output  5  tag returned with the response.

Behaviour:
- Grant
  - data_gnt_o = data_req_in while reset is deasserted; combinational.
  - Memory is always ready: no wait states.
  - data_gnt_o = 0 while reset is asserted.
- Addressing
  - Word index = data_add_in[ADDR_W+1:2].
  - Bits [1:0] are ignored; misalignment handling is the LSU's job.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Write (data_req_in=1, data_we_in=1 at rising edge)
  - Each byte lane with its data_be_in bit set is written from data_wdata_in.
  - Lanes with the bit clear keep their value.
  - data_be_in=0000 writes nothing but still produces a response.
- Read (data_req_in=1, data_we_in=0 at rising edge)
  - The addressed word is registered into data_rdata_o.
  - data_be_in is ignored; sign/zero extension and byte selection are done by the LSU.
- Response
  - Next cycle after any granted request: data_rvalid=1 for exactly one cycle.
  - rd_out_data = rd_in_data captured with the request.
  - For writes, data_rdata_o = 0.
  - Latency is 1 cycle.
  - Back-to-back requests every cycle are accepted, giving continuous rvalid.
- Idle (data_req_in=0): next cycle data_rvalid=0; data_rdata_o and rd_out_data hold their last values.
- Read-after-write
  - Write to word W in cycle N, read of W in cycle N+1: the read returns the newly written data.
  - Write-then-read ordering is inherent to the single port.
- Reset
  - On assertion, asynchronously: data_rvalid=0, data_rdata_o=0, rd_out_data=0.
  - Memory contents are NOT cleared and remain unchanged.
  - A request in flight when reset asserts produces no response.
  - The first request is sampled on the first rising edge after reset deasserts.
- X handling: if data_req_in is X/unknown, treat it as no request for state updates; no write occurs.

Test Plan:
- Reset: assert reset mid-response (rvalid=1) → rvalid, rdata, rd_out_data go to 0 immediately; a prior write to addr 0x10 is still readable after release.
- Full write/read:
  - Write 0xDEADBEEF, be=1111, addr 0x00000040.
  - Next cycle: rvalid=1, rdata=0.
  - Read addr 0x40, rd_in_data=5 → one cycle later rdata=0xDEADBEEF, rd_out_data=5, rvalid=1.
- Byte enables:
  - Word 0x40 holds 0xDEADBEEF.
  - Write data 0x11223344 with be=0101 → read returns 0xDE22BE44.
  - Write with be=0000 → word unchanged.
- Alignment and wrap:
  - Read addr 0x43 returns the same word as 0x40.
  - Addr 0x40 + DEPTH_WORDS*4 aliases to word 0x40.
- Throughput and hazard:
  - Write 0x0000000A to 0x80 in cycle N, read 0x80 with tag 7 in cycle N+1 → cycle N+2 rvalid=1, rdata=0x0000000A, rd_out_data=7.
  - No idle cycles between responses.
- Grant/idle: data_req_in=0 → gnt=0; the cycle after, rvalid=0 and rdata holds its last value; memory unmodified even with we=1 and be=1111.
